// File: rtl/row_buffer_n.sv
// ----------------------------------------------------------------------------
// row_buffer_n
//   N-row line buffer. Keeps ROWS-1 previous lines in circular line memories
//   addressed by the current column and presents ROWS column-aligned pixels
//   per accepted input pixel, one cycle later. Supports a runtime line width,
//   per-pixel valid, frame-start resync and top-border fill (zero/replicate).
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        global advance; 0 freezes all state and outputs
//   sof           start of frame (qualified by pixel_valid), column 0 of line 0
//   line_width    active pixels per line, latched on accepted sof
//   border_mode   0 = zero-fill unfilled rows, 1 = replicate oldest real line
//   pixel_valid   pixel_in qualifier
//   pixel_in      input pixel
//   rows_out      slice k = row k; row 0 oldest, row ROWS-1 = current line
//   out_valid     rows_out valid this cycle
//   out_full      all ROWS-1 stored lines belong to the current frame
//   out_col       column index of rows_out
// ----------------------------------------------------------------------------
module row_buffer_n #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MAX_LINE_WIDTH = 1920,
    parameter int unsigned ROWS           = 3,
    localparam int unsigned LW            = $clog2(MAX_LINE_WIDTH + 1),
    localparam int unsigned CW            = $clog2(MAX_LINE_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       sof,
    input  logic [LW-1:0]              line_width,
    input  logic                       border_mode,
    input  logic                       pixel_valid,
    input  logic [DATA_WIDTH-1:0]      pixel_in,
    output logic [ROWS*DATA_WIDTH-1:0] rows_out,
    output logic                       out_valid,
    output logic                       out_full,
    output logic [CW-1:0]              out_col
);

    localparam int unsigned NMEM  = ROWS - 1;
    localparam int unsigned LFW   = $clog2(ROWS);
    localparam logic [LW-1:0]  MAX_W  = LW'(MAX_LINE_WIDTH);
    localparam logic [LFW-1:0] LF_MAX = LFW'(ROWS - 1);

    logic [CW-1:0]         col;
    logic [LFW-1:0]        lines_filled;
    logic [LW-1:0]         width;
    logic                  border_q;

    logic [DATA_WIDTH-1:0] mem [NMEM][MAX_LINE_WIDTH];

    logic                  accept;
    logic [CW-1:0]         eff_col;
    logic [LFW-1:0]        eff_lf;
    logic [LW-1:0]         eff_width;
    logic                  eff_bmode;
    logic [LW-1:0]         sof_width;
    logic                  wrap;
    logic [DATA_WIDTH-1:0] rd [NMEM];
    logic [DATA_WIDTH-1:0] rep;
    logic [ROWS*DATA_WIDTH-1:0] rows_d;

    assign accept = enable & pixel_valid;

    // An accepted sof takes effect for its own pixel: the pixel lands at
    // column 0 of a fresh frame using the newly latched width/border mode.
    always_comb begin
        sof_width = line_width;
        if (line_width == '0 || line_width > MAX_W)
            sof_width = MAX_W;
        eff_col   = col;
        eff_lf    = lines_filled;
        eff_width = width;
        eff_bmode = border_q;
        if (sof) begin
            eff_col   = '0;
            eff_lf    = '0;
            eff_width = sof_width;
            eff_bmode = border_mode;
        end
        wrap = ((LW'(eff_col) + LW'(1)) == eff_width);
    end

    // Read side of the line memories: mem j holds line L-j-1 at eff_col.
    always_comb begin
        for (int unsigned j = 0; j < NMEM; j++)
            rd[j] = mem[j][eff_col];
    end

    // Row assembly with top-border handling. Row k has delay ROWS-1-k;
    // it is real only while its delay does not exceed lines_filled.
    always_comb begin
        rep = pixel_in;
        for (int unsigned j = 1; j <= NMEM; j++)
            if (eff_lf == LFW'(j))
                rep = rd[j-1];
        rows_d = '0;
        for (int unsigned k = 0; k < ROWS; k++) begin
            if (k == ROWS - 1)
                rows_d[k*DATA_WIDTH +: DATA_WIDTH] = pixel_in;
            else if (LFW'(ROWS - 1 - k) <= eff_lf)
                rows_d[k*DATA_WIDTH +: DATA_WIDTH] = rd[ROWS-2-k];
            else if (eff_bmode)
                rows_d[k*DATA_WIDTH +: DATA_WIDTH] = rep;
            else
                rows_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col          <= '0;
            lines_filled <= '0;
            width        <= MAX_W;
            border_q     <= 1'b0;
            rows_out     <= '0;
            out_valid    <= 1'b0;
            out_full     <= 1'b0;
            out_col      <= '0;
        end else if (enable) begin
            if (pixel_valid) begin
                col       <= wrap ? '0 : eff_col + 1'b1;
                if (wrap && eff_lf != LF_MAX)
                    lines_filled <= eff_lf + 1'b1;
                else
                    lines_filled <= eff_lf;
                width     <= eff_width;
                border_q  <= eff_bmode;
                rows_out  <= rows_d;
                out_valid <= 1'b1;
                out_full  <= (eff_lf == LF_MAX);
                out_col   <= eff_col;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Line memories are not reset; read-before-write shifts each line one
    // memory deeper at the same column.
    always_ff @(posedge clk) begin
        if (accept && rst_n) begin
            mem[0][eff_col] <= pixel_in;
            for (int unsigned j = 1; j < NMEM; j++)
                mem[j][eff_col] <= rd[j-1];
        end
    end

endmodule

// File: tb/tb_row_buffer_n.sv
module tb_row_buffer_n;

    localparam int DW   = 8;
    localparam int MAXW = 1920;
    localparam int LW   = 11;
    localparam int CW   = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          sof = 1'b0;
    logic [LW-1:0] line_width = '0;
    logic          border_mode = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [DW-1:0] pixel_in = '0;

    logic [3*DW-1:0] rows3;
    logic            v3, f3;
    logic [CW-1:0]   c3;
    logic [5*DW-1:0] rows5;
    logic            v5, f5;
    logic [CW-1:0]   c5;

    always #5 clk = ~clk;

    row_buffer_n #(.DATA_WIDTH(DW), .MAX_LINE_WIDTH(MAXW), .ROWS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sof(sof),
        .line_width(line_width), .border_mode(border_mode),
        .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .rows_out(rows3), .out_valid(v3), .out_full(f3), .out_col(c3));

    row_buffer_n #(.DATA_WIDTH(DW), .MAX_LINE_WIDTH(MAXW), .ROWS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sof(sof),
        .line_width(line_width), .border_mode(border_mode),
        .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .rows_out(rows5), .out_valid(v5), .out_full(f5), .out_col(c5));

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference: every pixel of the current frame by (line, col).
    logic [DW-1:0] hist [int];
    int  m_line, m_col, m_width;
    bit  m_bm;
    logic [3*DW-1:0] e_rows3;
    logic [5*DW-1:0] e_rows5;
    bit  e_valid, e_full3, e_full5;
    int  e_col;

    function automatic int key(int l, int c);
        return l * 2048 + c;
    endfunction

    function automatic logic [DW-1:0] row_val(int r, int d, logic [DW-1:0] px);
        int lf;
        lf = (m_line < r - 1) ? m_line : r - 1;
        if (d == 0) return px;
        if (d <= lf) return hist[key(m_line - d, m_col)];
        if (!m_bm) return '0;
        if (lf == 0) return px;
        return hist[key(m_line - lf, m_col)];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_line = 0; m_col = 0; m_width = MAXW; m_bm = 0;
        e_rows3 = '0; e_rows5 = '0; e_valid = 0; e_full3 = 0; e_full5 = 0; e_col = 0;
    endtask

    task automatic model_edge();
        if (!enable) return;
        if (!pixel_valid) begin
            e_valid = 0;
            return;
        end
        if (sof) begin
            hist.delete();
            m_line = 0; m_col = 0; m_bm = border_mode;
            m_width = (line_width == 0 || int'(line_width) > MAXW) ? MAXW : int'(line_width);
        end
        hist[key(m_line, m_col)] = pixel_in;
        for (int d = 0; d < 3; d++) e_rows3[(2-d)*DW +: DW] = row_val(3, d, pixel_in);
        for (int d = 0; d < 5; d++) e_rows5[(4-d)*DW +: DW] = row_val(5, d, pixel_in);
        e_full3 = (m_line >= 2);
        e_full5 = (m_line >= 4);
        e_valid = 1;
        e_col   = m_col;
        m_col++;
        if (m_col == m_width) begin
            m_col = 0;
            m_line++;
        end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        check("valid3", 64'(v3), 64'(e_valid));
        check("valid5", 64'(v5), 64'(e_valid));
        check("col3", 64'(c3), 64'(e_col));
        check("col5", 64'(c5), 64'(e_col));
        check("rows3", 64'(rows3), 64'(e_rows3));
        check("rows5", 64'(rows5), 64'(e_rows5));
        check("full3", 64'(f3), 64'(e_full3));
        check("full5", 64'(f5), 64'(e_full5));
    endtask

    task automatic step(input bit en, input bit pv, input bit sf, input bit bm,
                        input logic [LW-1:0] lw, input logic [DW-1:0] px);
        enable = en; pixel_valid = pv; sof = sf; border_mode = bm;
        line_width = lw; pixel_in = px;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    logic [3*DW-1:0] held;
    int i, k;

    initial begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        check("reset_rows3", 64'(rows3), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Ramp, zero mode, ROWS=3 pinned values.
        for (i = 0; i < 16; i++) begin
            step(1, 1, i == 0, 0, 11'd4, 8'(i));
            if (i == 1) begin
                check("t1_l0c1", 64'(rows3), 64'({8'd1, 8'd0, 8'd0}));
                check("t1_l0c1_full", 64'(f3), 64'd0);
            end
            if (i == 9) begin
                check("t1_l2c1", 64'(rows3), 64'({8'd9, 8'd5, 8'd1}));
                check("t1_l2c1_full", 64'(f3), 64'd1);
            end
        end

        // Replicate mode.
        for (i = 0; i < 16; i++) begin
            step(1, 1, i == 0, 1, 11'd4, 8'(i));
            if (i == 3) check("t2_l0c3", 64'(rows3), 64'({8'd3, 8'd3, 8'd3}));
            if (i == 6) check("t2_l1c2", 64'(rows3), 64'({8'd6, 8'd2, 8'd2}));
        end

        // Gaps and a 5-cycle stall mid-line; ignored inputs carry junk.
        i = 0;
        while (i < 16) begin
            if (i == 6) begin
                held = rows3;
                for (int s = 0; s < 5; s++) begin
                    step(0, 1'($urandom), 1'($urandom), 1'($urandom), 11'($urandom), 8'($urandom));
                    check("stall_hold", 64'(rows3), 64'(held));
                end
                step(1, 1, 0, 1'($urandom), 11'($urandom), 8'(i));
                i++;
            end else if ($urandom_range(0, 2) == 0) begin
                step(1, 0, 1'($urandom), 1'($urandom), 11'($urandom), 8'($urandom));
            end else begin
                step(1, 1, i == 0, (i == 0) ? 1'b0 : 1'($urandom), (i == 0) ? 11'd4 : 11'($urandom), 8'(i));
                if (i == 9) check("t3_l2c1", 64'(rows3), 64'({8'd9, 8'd5, 8'd1}));
                i++;
            end
        end

        // sof mid-line at column 2 of line 2, new width 6.
        for (i = 0; i < 10; i++) step(1, 1, i == 0, 0, 11'd4, 8'(i));
        step(1, 1, 1, 0, 11'd6, 8'd200);
        check("t4_sof_col", 64'(c3), 64'd0);
        check("t4_sof_full", 64'(f3), 64'd0);
        check("t4_sof_rows01", 64'(rows3[15:0]), 64'd0);
        for (i = 0; i < 14; i++) begin
            step(1, 1, 0, 0, 11'($urandom), 8'($urandom));
            if (i == 4) check("t4_w6_lastcol", 64'(c3), 64'd5);
            if (i == 5) check("t4_w6_wrap", 64'(c3), 64'd0);
        end

        // Full-width frame, 6 lines, ROWS=5; line_width 0 latches as MAX.
        k = 0;
        while (k < 6 * MAXW) begin
            if ($urandom_range(0, 9) == 0) begin
                step(1, 0, 1'($urandom), 1'($urandom), 11'($urandom), 8'($urandom));
            end else begin
                step(1, 1, k == 0, (k == 0) ? 1'b0 : 1'($urandom), (k == 0) ? 11'd0 : 11'($urandom), 8'($urandom));
                if (k == MAXW - 1)     check("t5_lastcol", 64'(c5), 64'd1919);
                if (k == MAXW)         check("t5_wrap", 64'(c5), 64'd0);
                if (k == 4 * MAXW - 1) check("t5_full_before", 64'(f5), 64'd0);
                if (k == 4 * MAXW)     check("t5_full_rise", 64'(f5), 64'd1);
                k++;
            end
        end

        // Oversized line_width clamps to MAX, replicate mode.
        for (k = 0; k < MAXW + 3; k++) step(1, 1, k == 0, 1, 11'd2000, 8'($urandom));

        // Asynchronous reset mid-line 3.
        for (i = 0; i < 14; i++) step(1, 1, i == 0, 0, 11'd4, 8'(i + 20));
        @(negedge clk) rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        check("t6_rst_valid", 64'(v3), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step(1, 1, 0, 0, 11'd4, 8'd77);
        check("t6_after_col", 64'(c3), 64'd0);
        check("t6_after_rows", 64'(rows3), 64'({8'd77, 8'd0, 8'd0}));
        for (i = 0; i < 8; i++) step(1, 1'($urandom), 0, 1'($urandom), 11'($urandom), 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
